spi_slave_param: RTL and testbench

Parametrised next-generation SPI slave, clocked directly by SCLK with chip select CS, serial lines MOSI/MISO, and parallel tx/rx words toward the core.
- Generalises the fixed 8-bit, LSB-first, single-word slave to configurable word width, bit order and clock polarity.
- Adds multi-word bursts within one CS assertion, a per-word receive strobe and a word counter.
- Sits between the board-level SPI pins and the register/core logic.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_shift_ctr.sv | 37 +++
 rtl/spi_slave_param.sv | 144 ++++++++++++++
 tb/tb_spi_slave_param.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI constants: mode encodings, default sizes and bit-order enum.
package spi_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 8;

    // {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    typedef enum logic {
        ORDER_MSB = 1'b0,
        ORDER_LSB = 1'b1
    } bit_order_e;

endpackage

// File: rtl/spi_shift_ctr.sv
// Modulo-WIDTH bit counter with wrap flag; NEG_EDGE selects the active edge.
module spi_shift_ctr #(
    parameter int WIDTH    = 8,
    parameter bit NEG_EDGE = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    output logic [$clog2(WIDTH)-1:0] o_cnt,
    output logic                     o_wrap
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_next;

    assign o_wrap = (r_cnt == LAST);
    assign w_next = (i_clr || o_wrap) ? '0 : r_cnt + 1'b1;
    assign o_cnt  = r_cnt;

    generate
        if (NEG_EDGE) begin : g_neg
            always_ff @(negedge i_clk or posedge i_rst) begin
                if (i_rst) r_cnt <= '0;
                else       r_cnt <= w_next;
            end
        end else begin : g_pos
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) r_cnt <= '0;
                else       r_cnt <= w_next;
            end
        end
    endgenerate

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave with multi-word bursts, clocked directly by SCLK.
// Optional rxAck/overrun tracking enabled by SPI_SLAVE_OVERRUN_EN.
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1,
    parameter bit CPOL      = 1'b0,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic             SCLK,
    input  logic             reset,
    input  logic             CS,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] slaveDataToSend,
    output logic [WIDTH-1:0] slaveDataReceived,
    output logic             rxValid,
    output logic [CNT_W-1:0] wordCount,
    output logic             busy
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    input  logic             rxAck,
    output logic             overrun
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam bit_order_e ORDER = bit_order_e'(LSB_FIRST);

    logic             w_sclk;
    logic [CW-1:0]    w_txCnt;
    logic [CW-1:0]    w_rxCnt;
    logic             w_txWrap;
    logic             w_rxWrap;
    logic [WIDTH-1:0] w_rxNext;

    logic             r_txStart;
    logic [WIDTH-1:0] r_txShift;
    logic             r_miso;
    logic [WIDTH-1:0] r_rxShift;
    logic [WIDTH-1:0] r_dataRx;
    logic             r_rxValid;
    logic [CNT_W-1:0] r_wordCount;

    assign w_sclk = SCLK ^ CPOL;

    spi_shift_ctr #(.WIDTH(WIDTH), .NEG_EDGE(1'b0)) u_tx_ctr (
        .i_clk  (w_sclk),
        .i_rst  (reset),
        .i_clr  (CS),
        .o_cnt  (w_txCnt),
        .o_wrap (w_txWrap)
    );

    spi_shift_ctr #(.WIDTH(WIDTH), .NEG_EDGE(1'b1)) u_rx_ctr (
        .i_clk  (w_sclk),
        .i_rst  (reset),
        .i_clr  (CS),
        .o_cnt  (w_rxCnt),
        .o_wrap (w_rxWrap)
    );

    // r_txStart mirrors "txCnt will be zero at the next posedge"
    always_ff @(posedge w_sclk or posedge reset) begin
        if (reset) begin
            r_txStart <= 1'b1;
            r_txShift <= '0;
            r_miso    <= 1'b0;
        end else begin
            r_txStart <= CS | w_txWrap;
            if (!CS) begin
                if (r_txStart) begin
                    if (ORDER == ORDER_LSB) begin
                        r_miso    <= slaveDataToSend[0];
                        r_txShift <= slaveDataToSend >> 1;
                    end else begin
                        r_miso    <= slaveDataToSend[WIDTH-1];
                        r_txShift <= slaveDataToSend << 1;
                    end
                end else if (ORDER == ORDER_LSB) begin
                    r_miso    <= r_txShift[0];
                    r_txShift <= r_txShift >> 1;
                end else begin
                    r_miso    <= r_txShift[WIDTH-1];
                    r_txShift <= r_txShift << 1;
                end
            end
        end
    end

    assign w_rxNext = (ORDER == ORDER_LSB) ?
                      {MOSI, r_rxShift[WIDTH-1:1]} :
                      {r_rxShift[WIDTH-2:0], MOSI};

    always_ff @(negedge w_sclk or posedge reset) begin
        if (reset) begin
            r_rxShift   <= '0;
            r_dataRx    <= '0;
            r_rxValid   <= 1'b0;
            r_wordCount <= '0;
        end else if (CS) begin
            r_rxShift   <= '0;
            r_rxValid   <= 1'b0;
            r_wordCount <= '0;
        end else begin
            r_rxShift <= w_rxNext;
            if (w_rxWrap) begin
                r_dataRx    <= w_rxNext;
                r_rxValid   <= 1'b1;
                r_wordCount <= r_wordCount + 1'b1;
            end else begin
                r_rxValid   <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic r_pending;
    logic r_overrun;

    // An ack arriving with a completing word still retires the older word
    always_ff @(negedge w_sclk or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else if (!CS && w_rxWrap) begin
            r_pending <= 1'b1;
            if (r_pending && !rxAck) r_overrun <= 1'b1;
        end else if (rxAck) begin
            r_pending <= 1'b0;
        end
    end

    assign overrun = r_overrun;
`endif

    assign MISO              = CS ? 1'bz : r_miso;
    assign slaveDataReceived = r_dataRx;
    assign rxValid           = r_rxValid;
    assign wordCount         = r_wordCount;
    assign busy              = (w_rxCnt != '0) | (w_txCnt != '0);

endmodule

// File: tb/tb_spi_slave_param.sv
// Self-checking bench for spi_slave_param: 8-bit LSB/CPOL0 and 16-bit MSB/CPOL1.
module tb_spi_slave_param;

    typedef struct {
        logic [7:0] m;
        logic [7:0] s;
        bit         hold;
        bit         scr;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        logic [7:0] exp_wc;
    } vec_t;

    int vecs = 0;
    int errs = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        csA, mosiA;
    logic [7:0]  sdsA;
    wire         misoA;
    logic [7:0]  rxA;
    logic        rvA;
    logic [7:0]  wcA;
    logic        busyA;

    logic        sclkB;
    logic        csB, mosiB;
    logic [15:0] sdsB;
    wire         misoB;
    logic [15:0] rxB;
    logic        rvB;
    logic [7:0]  wcB;
    logic        busyB;

`ifdef SPI_SLAVE_OVERRUN_EN
    logic ackA = 1'b0;
    logic ovA;
    logic ackB = 1'b0;
    logic ovB;
`endif

    logic [7:0] sbA[$];
    logic       prevA = 1'b0;
    vec_t       tbl[8];

    pullup (misoA);

    always #5 clk = ~clk;
    assign sclkB = ~clk;

    spi_slave_param #(
        .WIDTH(8), .LSB_FIRST(1'b1), .CPOL(1'b0), .CNT_W(8)
    ) dutA (
        .SCLK              (clk),
        .reset             (rst),
        .CS                (csA),
        .MOSI              (mosiA),
        .MISO              (misoA),
        .slaveDataToSend   (sdsA),
        .slaveDataReceived (rxA),
        .rxValid           (rvA),
        .wordCount         (wcA),
        .busy              (busyA)
`ifdef SPI_SLAVE_OVERRUN_EN
        ,
        .rxAck             (ackA),
        .overrun           (ovA)
`endif
    );

    spi_slave_param #(
        .WIDTH(16), .LSB_FIRST(1'b0), .CPOL(1'b1), .CNT_W(8)
    ) dutB (
        .SCLK              (sclkB),
        .reset             (rst),
        .CS                (csB),
        .MOSI              (mosiB),
        .MISO              (misoB),
        .slaveDataToSend   (sdsB),
        .slaveDataReceived (rxB),
        .rxValid           (rvB),
        .wordCount         (wcB),
        .busy              (busyB)
`ifdef SPI_SLAVE_OVERRUN_EN
        ,
        .rxAck             (ackB),
        .overrun           (ovB)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard consumer: every rxValid pulse must match the oldest sent word
    always @(negedge clk) begin
        #1;
        if (rvA) begin
            chk("rxvalid_width", {31'b0, prevA}, 32'd0);
            vecs++;
            if (sbA.size() == 0) begin
                errs++;
                $display("FAIL rxvalid_unexpected: got pulse, data %h expected none", rxA);
            end else begin
                logic [7:0] e;
                e = sbA.pop_front();
                vecs--;
                chk("sb_word", {24'b0, rxA}, {24'b0, e});
            end
        end
        prevA = rvA;
    end

    task automatic xfer_a(input logic [7:0] m, input logic [7:0] s,
                          input int nb, input bit scr,
                          output logic [7:0] got);
        got  = '0;
        csA  = 1'b0;
        sdsA = s;
        for (int i = 0; i < nb; i++) begin
            @(posedge clk);
            mosiA = m[i];
            @(negedge clk);
            got[i] = misoA;
            if (scr && i == 0) sdsA = ~s;
        end
        if (nb == 8) sbA.push_back(m);
        #1;
    endtask

    task automatic xfer_b(input logic [15:0] m, input logic [15:0] s,
                          output logic [15:0] got);
        got  = '0;
        csB  = 1'b0;
        sdsB = s;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            mosiB = m[15-i];
            @(negedge clk);
            got[15-i] = misoB;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        csA = 1'b1;
        csB = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0]  g8;
        logic [15:0] g16;

        tbl[0] = '{8'h53, 8'h09, 1'b0, 1'b0, 8'h53, 8'h09, 8'd1};
        tbl[1] = '{8'h3C, 8'h98, 1'b1, 1'b0, 8'h3C, 8'h98, 8'd1};
        tbl[2] = '{8'h55, 8'hFF, 1'b1, 1'b0, 8'h55, 8'hFF, 8'd2};
        tbl[3] = '{8'h5F, 8'h98, 1'b0, 1'b0, 8'h5F, 8'h98, 8'd3};
        tbl[4] = '{8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 8'hFF, 8'd1};
        tbl[5] = '{8'hFF, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h00, 8'd1};
        tbl[6] = '{8'hC6, 8'h5A, 1'b1, 1'b1, 8'hC6, 8'h5A, 8'd1};
        tbl[7] = '{8'h80, 8'h01, 1'b0, 1'b0, 8'h80, 8'h01, 8'd2};

        mosiA = 1'b0; sdsA = '0;
        mosiB = 1'b0; sdsB = '0;
        rst = 1'b1; csA = 1'b1; csB = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rx",    {24'b0, rxA}, 32'd0);
        chk("rst_valid", {31'b0, rvA}, 32'd0);
        chk("rst_wc",    {24'b0, wcA}, 32'd0);
        chk("rst_busy",  {31'b0, busyA}, 32'd0);
        chk("rst_hiz",   {31'b0, (misoA !== 1'b0)}, 32'd1);
        chk("rst_rxB",   {16'b0, rxB}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;

        for (int k = 0; k < 8; k++) begin
            xfer_a(tbl[k].m, tbl[k].s, 8, tbl[k].scr, g8);
            chk("rx_data",  {24'b0, rxA}, {24'b0, tbl[k].exp_rx});
            chk("miso_word", {24'b0, g8}, {24'b0, tbl[k].exp_miso});
            chk("word_cnt", {24'b0, wcA}, {24'b0, tbl[k].exp_wc});
            chk("rx_valid", {31'b0, rvA}, 32'd1);
            chk("busy_end", {31'b0, busyA}, 32'd0);
            if (!tbl[k].hold) begin
                csA = 1'b1;
                @(negedge clk);
                #1;
                chk("wc_clear", {24'b0, wcA}, 32'd0);
                chk("valid_clr", {31'b0, rvA}, 32'd0);
            end
        end

        // Aborted word: no strobe, previous word kept
        xfer_a(8'hA5, 8'h3C, 5, 1'b0, g8);
        chk("abort_busy", {31'b0, busyA}, 32'd1);
        csA = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("abort_rx",   {24'b0, rxA}, {24'b0, tbl[7].exp_rx});
        chk("abort_busy0", {31'b0, busyA}, 32'd0);
        xfer_a(8'h0F, 8'hC3, 8, 1'b0, g8);
        chk("after_rx",   {24'b0, rxA}, 32'h0F);
        chk("after_miso", {24'b0, g8}, 32'hC3);
        chk("after_wc",   {24'b0, wcA}, 32'd1);
        csA = 1'b1;
        @(negedge clk);
        #1;

        // 16-bit MSB-first, CPOL=1 instance
        xfer_b(16'hBEEF, 16'h1234, g16);
        chk("b_rx",    {16'b0, rxB}, 32'hBEEF);
        chk("b_miso",  {16'b0, g16}, 32'h1234);
        chk("b_valid", {31'b0, rvB}, 32'd1);
        chk("b_wc",    {24'b0, wcB}, 32'd1);
        xfer_b(16'h8001, 16'hA5C3, g16);
        chk("b_rx2",   {16'b0, rxB}, 32'h8001);
        chk("b_miso2", {16'b0, g16}, 32'hA5C3);
        chk("b_wc2",   {24'b0, wcB}, 32'd2);
        csB = 1'b1;
        @(negedge clk);
        #1;
        chk("b_valid0", {31'b0, rvB}, 32'd0);

        // Async reset in the middle of the second word of a burst
        xfer_a(8'h66, 8'h99, 8, 1'b0, g8);
        xfer_a(8'h12, 8'h34, 4, 1'b0, g8);
        chk("pre_rst_wc",   {24'b0, wcA}, 32'd1);
        chk("pre_rst_busy", {31'b0, busyA}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_rx",   {24'b0, rxA}, 32'd0);
        chk("mid_rst_wc",   {24'b0, wcA}, 32'd0);
        chk("mid_rst_busy", {31'b0, busyA}, 32'd0);
        chk("mid_rst_val",  {31'b0, rvA}, 32'd0);
        csA = 1'b1;
        #1;
        chk("mid_rst_hiz",  {31'b0, (misoA !== 1'b0)}, 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;

`ifdef SPI_SLAVE_OVERRUN_EN
        do_reset();
        chk("ov_rst", {31'b0, ovA}, 32'd0);
        xfer_a(8'h11, 8'h00, 8, 1'b0, g8);
        chk("ov_first", {31'b0, ovA}, 32'd0);
        xfer_a(8'h22, 8'h00, 8, 1'b0, g8);
        chk("ov_set", {31'b0, ovA}, 32'd1);
        csA = 1'b1;
        @(negedge clk);
        #1;
        do_reset();
        chk("ov_clr", {31'b0, ovA}, 32'd0);
        xfer_a(8'h33, 8'h00, 8, 1'b0, g8);
        ackA = 1'b1;
        fork
            begin
                @(negedge clk);
                #1;
                ackA = 1'b0;
            end
        join_none
        xfer_a(8'h44, 8'h00, 8, 1'b0, g8);
        chk("ov_acked", {31'b0, ovA}, 32'd0);
        csA = 1'b1;
        @(negedge clk);
        #1;
`endif

        repeat (2) @(negedge clk);
        #2;
        chk("sb_empty", sbA.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
